// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the 8-point DIT FFT front end: fills the input shift register,
// steps butterfly stages one-hot, then hands the result off. FFT_SEQ_FRAME_CNT_EN adds frame_cnt.
module fft_frame_sequencer #(
  parameter int unsigned N_POINTS     = 8,
  parameter int unsigned LOG2N        = 3,
  parameter int unsigned STAGE_CYCLES = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  input  logic             flush,
  output logic [LOG2N-1:0] stage_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef FFT_SEQ_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic [CNT_W-1:0] fill_level
);

  localparam int unsigned SIDX_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  typedef enum logic [1:0] {FILL, STAGE, DONE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  sample_cnt, sample_n;
  logic [CNT_W-1:0]  cyc_cnt, cyc_n;
  logic [SIDX_W-1:0] stage_idx, sidx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      sample_cnt <= '0;
      cyc_cnt    <= '0;
      stage_idx  <= '0;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_n;
      cyc_cnt    <= cyc_n;
      stage_idx  <= sidx_n;
    end
  end

  always_comb begin
    state_n  = state;
    sample_n = sample_cnt;
    cyc_n    = cyc_cnt;
    sidx_n   = stage_idx;
    // flush wins over every state transition, including a same-cycle result handshake
    if (flush) begin
      state_n  = FILL;
      sample_n = '0;
      cyc_n    = '0;
      sidx_n   = '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (sample_cnt == CNT_W'(N_POINTS - 1)) begin
              state_n  = STAGE;
              sample_n = '0;
              cyc_n    = '0;
              sidx_n   = '0;
            end else begin
              sample_n = sample_cnt + CNT_W'(1);
            end
          end
        end
        STAGE: begin
          if (cyc_cnt == CNT_W'(STAGE_CYCLES - 1)) begin
            cyc_n = '0;
            if (stage_idx == SIDX_W'(LOG2N - 1)) begin
              state_n = DONE;
              sidx_n  = '0;
            end else begin
              sidx_n = stage_idx + SIDX_W'(1);
            end
          end else begin
            cyc_n = cyc_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_n = FILL;
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state == FILL);
    busy       = (state != FILL);
    out_valid  = (state == DONE);
    fill_level = sample_cnt;
    stage_en   = '0;
    if (state == STAGE) stage_en = LOG2N'(1) << stage_idx;
  end

  assign shift_en = in_valid & in_ready;

`ifdef FFT_SEQ_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready && !flush) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer (N_POINTS=8, LOG2N=3, STAGE_CYCLES=2).
// Stimulus queues the hand-derived per-cycle output vector; the monitor compares at negedge.
module tb_fft_frame_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       shift_en;
  logic       flush;
  logic [2:0] stage_en;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [3:0] fill_level;
`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  fft_frame_sequencer #(
    .N_POINTS(8),
    .LOG2N(3),
    .STAGE_CYCLES(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .shift_en(shift_en),
    .flush(flush),
    .stage_en(stage_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
`ifdef FFT_SEQ_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .fill_level(fill_level)
  );

  typedef struct packed {
    logic       ir;
    logic       se;
    logic [2:0] st;
    logic       ov;
    logic       busy;
    logic [3:0] fill;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t e_fill(input int f, input logic se);
    exp_t e;
    e.ir = 1'b1; e.se = se; e.st = 3'b000; e.ov = 1'b0; e.busy = 1'b0; e.fill = 4'(f);
    return e;
  endfunction

  function automatic exp_t e_stage(input logic [2:0] st);
    exp_t e;
    e.ir = 1'b0; e.se = 1'b0; e.st = st; e.ov = 1'b0; e.busy = 1'b1; e.fill = 4'd0;
    return e;
  endfunction

  function automatic exp_t e_done();
    exp_t e;
    e.ir = 1'b0; e.se = 1'b0; e.st = 3'b000; e.ov = 1'b1; e.busy = 1'b1; e.fill = 4'd0;
    return e;
  endfunction

  // Monitor: one expected vector per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.ir = in_ready; a.se = shift_en; a.st = stage_en; a.ov = out_valid;
      a.busy = busy; a.fill = fill_level;
      checks++;
      if (a !== e)
        $display("FAIL %s @%0t: got ir=%b se=%b st=%b ov=%b busy=%b fill=%0d, expected ir=%b se=%b st=%b ov=%b busy=%b fill=%0d",
                 n, $time, a.ir, a.se, a.st, a.ov, a.busy, a.fill,
                 e.ir, e.se, e.st, e.ov, e.busy, e.fill);
      else
        passes++;
    end
  end

  task automatic step(input logic r, input logic v, input logic f, input logic ordy,
                      input exp_t e, input string nm);
    rst = r; in_valid = v; flush = f; out_ready = ordy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic fill_frame(input string nm);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, e_fill(i, 1'b1), nm);
  endtask

  // Three stages of two cycles each, DONE held `wait_n` cycles, then handshake and FILL check.
  task automatic compute(input int wait_n, input logic v);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++)
        step(1'b0, v, 1'b0, 1'b0, e_stage(3'b001 << k), "stage_seq");
    for (int d = 0; d < wait_n; d++) step(1'b0, v, 1'b0, 1'b0, e_done(), "done_hold");
    step(1'b0, v, 1'b0, 1'b1, e_done(), "done_hs");
    step(1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b0), "post_hs_fill");
  endtask

`ifdef FFT_SEQ_FRAME_CNT_EN
  task automatic chk_fc(input logic [15:0] want, input string nm);
    checks++;
    if (frame_cnt !== want)
      $display("FAIL %s: got frame_cnt=%0d, expected %0d", nm, frame_cnt, want);
    else
      passes++;
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    logic pat [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    step(1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b0), "reset_vals");
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk_fc(16'd0, "fc_reset");
`endif

    // Back-to-back frame, in_valid held high through compute
    fill_frame("b2b_fill");
    compute(0, 1'b1);

    // Gapped frame; DONE held 5 cycles with in_valid asserted
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, pat[i], 1'b0, 1'b0, e_fill(cnt, pat[i]), "gap_fill");
      if (pat[i]) cnt++;
    end
    compute(5, 1'b1);

    // Flush at fill_level 5 with a sample presented; it shifts but is not counted
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, e_fill(i, 1'b1), "pre_flush_fill");
    step(1'b0, 1'b1, 1'b1, 1'b0, e_fill(5, 1'b1), "flush_fill_cycle");
    step(1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b0), "after_fill_flush");
    fill_frame("refill_after_flush");
    compute(0, 1'b0);

    // Flush during stage 1
    fill_frame("fill_stage_flush");
    step(1'b0, 1'b0, 1'b0, 1'b0, e_stage(3'b001), "stage0_a");
    step(1'b0, 1'b0, 1'b0, 1'b0, e_stage(3'b001), "stage0_b");
    step(1'b0, 1'b0, 1'b1, 1'b0, e_stage(3'b010), "stage1_flush");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b0), "after_stage_flush");

    // Flush together with the result handshake: not delivered
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk_fc(16'd3, "fc_before_flush_hs");
`endif
    fill_frame("fill_done_flush");
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++)
        step(1'b0, 1'b0, 1'b0, 1'b0, e_stage(3'b001 << k), "stage_seq2");
    step(1'b0, 1'b0, 1'b1, 1'b1, e_done(), "done_flush_hs");
    step(1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b0), "after_done_flush");
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk_fc(16'd3, "fc_flush_hs_ignored");
`endif

    // Reset during DONE with out_ready high
    fill_frame("fill_done_rst");
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++)
        step(1'b0, 1'b0, 1'b0, 1'b0, e_stage(3'b001 << k), "stage_seq3");
    step(1'b1, 1'b0, 1'b0, 1'b1, e_done(), "done_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, e_fill(0, 1'b0), "after_done_rst");
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk_fc(16'd0, "fc_after_rst");
`endif
    fill_frame("fill_post_rst");
    compute(0, 1'b0);
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk_fc(16'd1, "fc_one");
    fill_frame("fill_fc2");
    compute(0, 1'b0);
    fill_frame("fill_fc3");
    compute(0, 1'b0);
    chk_fc(16'd3, "fc_three");
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt;
    chk_fc(16'hFFFF, "fc_forced");
    fill_frame("fill_wrap");
    compute(0, 1'b0);
    chk_fc(16'd0, "fc_wrap");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending vectors, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
